// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared register map, FSM encoding and priority helper for intc
package intc_pkg;

  localparam logic [1:0] INTC_PEND = 2'd0;
  localparam logic [1:0] INTC_MASK = 2'd1;
  localparam logic [1:0] INTC_EDGE = 2'd2;
  localparam logic [1:0] INTC_VEC  = 2'd3;

  localparam int VEC_VALID_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } intc_state_e;

  // Index of the lowest set bit (source 0 has the highest priority); 0 when empty.
  function automatic logic [2:0] prio_idx(input logic [7:0] v);
    prio_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) prio_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/intc_sync.sv
// rtl/intc_sync.sv - irq input synchroniser with rising-edge detect
module intc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic irq_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], irq_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/intc.sv
// rtl/intc.sv - memory-mapped interrupt controller: mask, edge/level, fixed priority, vector/EOI
module intc
  import intc_pkg::*;
#(
  parameter int NSRC        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      AD,
  input  logic [7:0]      DI,
  output logic [7:0]      DO,
  input  logic            rw,
  input  logic            cs,
  input  logic [NSRC-1:0] irq_in,
  output logic            intr
);

  localparam logic [7:0] IMPL = 8'((16'd1 << NSRC) - 16'd1);

  logic [7:0]  level, rise;
  logic [7:0]  pend_q, pend_d, mask_q, mask_d, edge_q, edge_d;
  logic [2:0]  isv_q, isv_d;
  logic        rd_q, intr_q;
  intc_state_e state_q, state_d;

  logic       wr, vec_rd, rd_strobe, valid, take;
  logic [7:0] act, w1c, svc_clr;
  logic [2:0] idx;

  for (genvar g = 0; g < 8; g++) begin : g_src
    if (g < NSRC) begin : g_on
      intc_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .irq_i  (irq_in[g]),
        .level_o(level[g]),
        .rise_o (rise[g])
      );
    end else begin : g_off
      assign level[g] = 1'b0;
      assign rise[g]  = 1'b0;
    end
  end

  always_comb begin
    wr        = cs & ~rw;
    vec_rd    = cs & rw & (AD == INTC_VEC);
    rd_strobe = vec_rd & ~rd_q;
    act       = pend_q & mask_q;
    valid     = |act;
    idx       = prio_idx(act);
    take      = (state_q == ST_ASSERT) && rd_strobe && valid;
    w1c       = (wr && AD == INTC_PEND) ? DI : 8'h00;
    svc_clr   = take ? (8'd1 << idx) : 8'h00;
  end

  // Edge bits: latch rises, set beats any clear in the same cycle. Level bits follow the input.
  always_comb begin
    pend_d = IMPL & ((edge_q & ((pend_q & ~w1c & ~svc_clr) | rise)) | (~edge_q & level));
    mask_d = (wr && AD == INTC_MASK) ? (DI & IMPL) : mask_q;
    edge_d = (wr && AD == INTC_EDGE) ? (DI & IMPL) : edge_q;
    isv_d  = take ? idx : isv_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (valid) state_d = ST_ASSERT;
      ST_ASSERT: begin
        if (take)        state_d = ST_SERVICE;
        else if (!valid) state_d = ST_IDLE;
      end
      ST_SERVICE: if (wr && AD == INTC_VEC) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pend_q  <= 8'h00;
      mask_q  <= 8'h00;
      edge_q  <= 8'h00;
      isv_q   <= 3'd0;
      rd_q    <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      isv_q   <= isv_d;
      rd_q    <= vec_rd;
      intr_q  <= (state_d == ST_ASSERT);
    end
  end

  assign intr = intr_q;

  always_comb begin
    DO = 8'h00;
    case (AD)
      INTC_PEND: DO = pend_q;
      INTC_MASK: DO = mask_q;
      INTC_EDGE: DO = edge_q;
      default: begin
        if (state_q == ST_SERVICE) begin
          DO[VEC_VALID_BIT] = 1'b1;
          DO[2:0]           = isv_q;
        end else if (state_q == ST_ASSERT) begin
          DO[VEC_VALID_BIT] = valid;
          DO[2:0]           = idx;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_intc.sv
// tb/tb_intc.sv - randomized self-checking bench for intc against a behavioural model
module tb_intc;

  localparam int NSRC = 8;
  localparam int SYNC = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      AD = 2'd0;
  logic [7:0]      DI = 8'h00;
  logic [7:0]      DO;
  logic            rw = 1'b1;
  logic            cs = 1'b0;
  logic [NSRC-1:0] irq_in = '0;
  logic            intr;

  intc #(.NSRC(NSRC), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO),
    .rw(rw), .cs(cs), .irq_in(irq_in), .intr(intr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: each pipeline stage and register held as plain arrays.
  typedef enum int {M_IDLE, M_ASSERT, M_SERVICE} mstate_t;
  bit      m_sync [SYNC][NSRC];
  bit      m_prev [NSRC];
  bit      m_pend [NSRC];
  bit      m_mask [NSRC];
  bit      m_edge [NSRC];
  mstate_t m_state;
  int      m_isv;
  bit      m_rd_prev;
  bit      m_intr;

  function automatic int lowest_active();
    for (int i = 0; i < NSRC; i++) if (m_pend[i] && m_mask[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] pack(input bit v [NSRC]);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < NSRC; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic logic [7:0] model_do();
    int lo = lowest_active();
    case (AD)
      2'd0: return pack(m_pend);
      2'd1: return pack(m_mask);
      2'd2: return pack(m_edge);
      default: begin
        if (m_state == M_SERVICE) return 8'h80 + 8'(m_isv);
        if (m_state == M_ASSERT && lo >= 0) return 8'h80 + 8'(lo);
        return 8'h00;
      end
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSRC; i++) begin
      for (int k = 0; k < SYNC; k++) m_sync[k][i] = 0;
      m_prev[i] = 0; m_pend[i] = 0; m_mask[i] = 0; m_edge[i] = 0;
    end
    m_state = M_IDLE; m_isv = 0; m_rd_prev = 0; m_intr = 0;
  endtask

  task automatic model_clock();
    int      lo    = lowest_active();
    bit      wr    = cs && !rw;
    bit      vrd   = cs && rw && AD == 2'd3;
    bit      strb  = vrd && !m_rd_prev;
    bit      taken = 0;
    mstate_t nxt   = m_state;
    bit      np [NSRC];
    case (m_state)
      M_IDLE:    if (lo >= 0) nxt = M_ASSERT;
      M_ASSERT:  if (strb && lo >= 0) begin nxt = M_SERVICE; taken = 1; end
                 else if (lo < 0) nxt = M_IDLE;
      M_SERVICE: if (wr && AD == 2'd3) nxt = M_IDLE;
      default:   nxt = M_IDLE;
    endcase
    for (int i = 0; i < NSRC; i++) begin
      bit s = m_sync[SYNC-1][i];
      if (m_edge[i]) begin
        np[i] = m_pend[i];
        if (wr && AD == 2'd0 && DI[i]) np[i] = 0;
        if (taken && lo == i) np[i] = 0;
        if (s && !m_prev[i]) np[i] = 1;
      end else begin
        np[i] = s;
      end
    end
    for (int i = 0; i < NSRC; i++) begin
      m_pend[i] = np[i];
      if (wr && AD == 2'd1) m_mask[i] = DI[i];
      if (wr && AD == 2'd2) m_edge[i] = DI[i];
      m_prev[i] = m_sync[SYNC-1][i];
      for (int k = SYNC-1; k > 0; k--) m_sync[k][i] = m_sync[k-1][i];
      m_sync[0][i] = irq_in[i];
    end
    if (taken) m_isv = lo;
    m_state   = nxt;
    m_rd_prev = vrd;
    m_intr    = (nxt == M_ASSERT);
  endtask

  logic [7:0] last_do;

  task automatic step();
    @(negedge clk);
    last_do = DO;
    chk("intr", {7'b0, intr}, {7'b0, m_intr});
    chk("do", DO, model_do());
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    step();
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; rw = 1'b1; AD = a;
    step();
    d  = last_do;
    cs = 1'b0;
  endtask

  logic [7:0] rd;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      chk("reset_reg", rd, 8'h00);
    end
    chk("reset_intr", {7'b0, intr}, 8'h00);

    // Level source 2
    bus_write(2'd1, 8'h04);
    irq_in = 8'h04;
    steps(3);
    chk("lvl_lat3", {7'b0, intr}, 8'h00);
    step();
    chk("lvl_lat4", {7'b0, intr}, 8'h01);
    bus_read(2'd3, rd);
    chk("lvl_vec", rd, 8'h82);
    chk("lvl_ack_intr", {7'b0, intr}, 8'h00);
    bus_write(2'd3, 8'h00);
    step();
    chk("lvl_reassert", {7'b0, intr}, 8'h01);
    irq_in = '0;
    bus_write(2'd1, 8'h00);
    steps(4);

    // Edge priority 1 over 3
    bus_write(2'd2, 8'h0A);
    bus_write(2'd1, 8'h0A);
    irq_in = 8'h08; step();
    irq_in = 8'h02; step();
    irq_in = 8'h00; steps(6);
    bus_read(2'd3, rd);
    chk("edge_vec1", rd, 8'h81);
    bus_write(2'd3, 8'h00);
    steps(2);
    bus_read(2'd3, rd);
    chk("edge_vec3", rd, 8'h83);
    bus_write(2'd3, 8'h00);
    bus_read(2'd0, rd);
    chk("edge_pend0", rd, 8'h00);

    // Masked level source 5
    bus_write(2'd1, 8'h00);
    irq_in = 8'h20;
    steps(5);
    chk("mask_intr0", {7'b0, intr}, 8'h00);
    bus_read(2'd0, rd);
    chk("mask_pend", rd, 8'h20);
    bus_write(2'd1, 8'h20);
    step();
    chk("mask_intr1", {7'b0, intr}, 8'h01);
    bus_read(2'd3, rd);
    chk("mask_vec", rd, 8'h85);
    irq_in = '0;
    bus_write(2'd3, 8'h00);
    bus_write(2'd1, 8'h00);
    steps(4);

    // Stretched VEC read with a fresh edge landing mid-read
    bus_write(2'd2, 8'h01);
    bus_write(2'd1, 8'h01);
    irq_in = 8'h01; step();
    irq_in = 8'h00; steps(5);
    irq_in = 8'h01;
    cs = 1'b1; rw = 1'b1; AD = 2'd3;
    steps(3);
    cs = 1'b0;
    irq_in = 8'h00;
    steps(3);
    bus_read(2'd0, rd);
    chk("stretch_pend", rd, 8'h01);
    bus_write(2'd3, 8'h00);
    steps(2);
    bus_read(2'd3, rd);
    chk("stretch_vec", rd, 8'h80);

    // W1C racing a rise pulse, still in SERVICE
    steps(2);
    irq_in = 8'h01;
    steps(2);
    bus_write(2'd0, 8'h01);
    bus_read(2'd0, rd);
    chk("w1c_race", rd, 8'h01);

    // Async reset mid-SERVICE
    AD = 2'd3;
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_intr", {7'b0, intr}, 8'h00);
    chk("rst_vec", DO, 8'h00);
    @(posedge clk);
    #1 rst = 1'b1;
    irq_in = '0;

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      if ($urandom_range(0, 3) == 0) begin
        logic [NSRC-1:0] t = irq_in;
        t[$urandom_range(0, NSRC-1)] ^= 1'b1;
        irq_in = t;
      end
      r = $urandom_range(0, 9);
      if (r < 4) begin
        step();
      end else if (r < 7) begin
        cs = 1'b1; rw = 1'b1; AD = 2'($urandom_range(0, 3));
        steps($urandom_range(1, 3));
        cs = 1'b0;
      end else begin
        bus_write(2'($urandom_range(0, 3)), 8'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
